aes_key_sched_multi: RTL and testbench



---
 rtl/aes_key_sched_multi.sv | 166 ++++++++++++++++
 tb/tb_aes_key_sched_multi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_multi.sv
// aes_key_sched_multi: iterative AES-128/192/256 key expansion into a round-key store.
// Define AES_KEY_SCHED_ZEROIZE_EN to clear the store on a rising edge of debug_mode.
module aes_key_sched_multi #(
    parameter int MAX_NK   = 8,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          key_len,
    input  logic [255:0]        key_in,
    input  logic                debug_mode,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                rk_valid,
    input  logic [RK_IDX_W-1:0] rk_idx,
    output logic [127:0]        rk_out
);
    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam logic [3:0] MAX_NK4 = 4'(MAX_NK);

    typedef enum logic [1:0] {IDLE, GEN, SUBW} state_t;

    state_t      state, state_nx;
    logic [31:0] store [DEPTH];
    logic [5:0]  i, tw, rb;
    logic [3:0]  nk, nk_req, nr;
    logic [2:0]  d;
    logic [7:0]  rcon;
    logic [31:0] s_word, prev, back, w_new, sub_in;
    logic        rot, legal, accept, reject, zero, sub_need, last_i, wr, rk_ok;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            p = y[0] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic debug_mode_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) debug_mode_d <= 1'b0;
        else     debug_mode_d <= debug_mode;
    end
    assign zero = debug_mode & ~debug_mode_d;
`else
    logic unused_debug;
    assign unused_debug = debug_mode;
    assign zero         = 1'b0;
`endif

    assign nk_req   = (key_len == 2'b00) ? 4'd4 : (key_len == 2'b01) ? 4'd6 : 4'd8;
    assign legal    = (key_len != 2'b11) && (nk_req <= MAX_NK4);
    assign accept   = (state == IDLE) && start && legal && !zero;
    assign reject   = (state == IDLE) && start && !legal && !zero;
    assign busy     = (state != IDLE);
    assign tw       = {nk + 4'd7, 2'b00};
    assign nr       = nk + 4'd6;
    assign prev     = store[i - 6'd1];
    assign back     = store[i - {2'b00, nk}];
    // d tracks (Nk - i mod Nk) mod Nk, so d==0 marks the RotWord positions
    assign sub_need = (d == 3'd0) || (nk == 4'd8 && d == 3'd4);
    assign sub_in   = (d == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    assign last_i   = (i == tw - 6'd1);

    always_comb begin
        state_nx = state;
        wr       = 1'b0;
        w_new    = back ^ prev;
        case (state)
            IDLE: state_nx = accept ? GEN : IDLE;
            GEN: begin
                wr       = !sub_need;
                state_nx = sub_need ? SUBW : (last_i ? IDLE : GEN);
            end
            SUBW: begin
                wr       = 1'b1;
                w_new    = back ^ s_word ^ {(rot ? rcon : 8'h00), 24'h0};
                state_nx = last_i ? IDLE : GEN;
            end
            default: state_nx = IDLE;
        endcase
        if (zero) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) store[6'(k)] <= '0;
            i        <= '0;
            nk       <= 4'd4;
            d        <= '0;
            rcon     <= 8'h01;
            s_word   <= '0;
            rot      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rk_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= reject;
            if (zero) begin
                for (int k = 0; k < DEPTH; k++) store[6'(k)] <= '0;
                rk_valid <= 1'b0;
            end else if (accept) begin
                for (int k = 0; k < 8; k++)
                    if (4'(k) < nk_req) store[6'(k)] <= key_in[255 - 32 * k -: 32];
                i        <= {2'b00, nk_req};
                nk       <= nk_req;
                d        <= '0;
                rcon     <= 8'h01;
                rk_valid <= 1'b0;
            end else begin
                if (state == GEN) begin
                    s_word <= sub_word(sub_in);
                    rot    <= (d == 3'd0);
                end
                if (wr) begin
                    store[i] <= w_new;
                    i        <= i + 6'd1;
                    d        <= (d == 3'd0) ? 3'(nk - 4'd1) : d - 3'd1;
                    if (state == SUBW && rot)
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (last_i) begin
                        done     <= 1'b1;
                        rk_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign rb     = 6'({rk_idx, 2'b00});
    assign rk_ok  = rk_valid && (32'(rk_idx) <= 32'(nr));
    assign rk_out = rk_ok ? {store[rb], store[rb + 6'd1], store[rb + 6'd2], store[rb + 6'd3]} : '0;

endmodule

// File: tb/tb_aes_key_sched_multi.sv
// tb_aes_key_sched_multi: scoreboard bench for aes_key_sched_multi using FIPS-197 key vectors.
// Zeroize expectations follow AES_KEY_SCHED_ZEROIZE_EN.
module tb_aes_key_sched_multi;
    logic         clk = 0, rst = 1, start = 0, start6 = 0, debug_mode = 0;
    logic [1:0]   key_len = 0, key_len6 = 0;
    logic [255:0] key_in = '0;
    logic [3:0]   rk_idx = 0;
    logic         busy, done, err, rk_valid, busy6, done6, err6, rk_valid6;
    logic [127:0] rk_out, rk_out6;

    typedef struct {string tag; int idx; logic [127:0] val;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_sched_multi dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
        .debug_mode(debug_mode), .busy(busy), .done(done), .err(err),
        .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_out(rk_out)
    );

    aes_key_sched_multi #(.MAX_NK(6), .RK_IDX_W(4)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .key_len(key_len6), .key_in(key_in),
        .debug_mode(1'b0), .busy(busy6), .done(done6), .err(err6),
        .rk_valid(rk_valid6), .rk_idx(rk_idx), .rk_out(rk_out6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int idx, input logic [127:0] val);
        q.push_back('{tag, idx, val});
    endtask

    task automatic launch(input bit six, input logic [1:0] len, input logic [255:0] key);
        @(negedge clk);
        key_in = key;
        if (six) begin key_len6 = len; start6 = 1; end
        else     begin key_len  = len; start  = 1; end
        @(posedge clk);
        #1 start = 0;
        start6 = 0;
    endtask

    task automatic wait_done(input bit six, output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (six ? done6 : done) break;
        end
    endtask

    task automatic drain(input bit six, input int n);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.idx < 0) check(e.tag, 128'(n), e.val);
            else begin
                rk_idx = 4'(e.idx);
                #1 check(e.tag, six ? rk_out6 : rk_out, e.val);
            end
        end
    endtask

    task automatic finish_run(input bit six, input int n);
        check("busy_end", six ? busy6 : busy, 1'b0);
        check("valid_end", six ? rk_valid6 : rk_valid, 1'b1);
        drain(six, n);
        @(negedge clk);
        check("done_pulse", six ? done6 : done, 1'b0);
    endtask

    task automatic no_done(input string tag, input int cycles);
        int cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check(tag, 128'(cnt), 128'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_valid", rk_valid, 1'b0);
        check("rst_rk", rk_out, 128'h0);
        rst = 0;

        push("lat128", -1, 128'd50);
        push("k128_rk0", 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        push("k128_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        push("k128_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        push("k128_rk11", 11, 128'h0);
        launch(0, 2'b00, K128);
        wait_done(0, n);
        finish_run(0, n);

        rk_idx = 10;
        @(negedge clk);
        key_len = 2'b11;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        check("err_pulse", err, 1'b1);
        check("err_busy", busy, 1'b0);
        check("err_valid", rk_valid, 1'b1);
        check("err_rk", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        check("err_clear", err, 1'b0);

        push("lat192", -1, 128'd54);
        push("k192_rk0", 0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        push("k192_rk1", 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        push("k192_rk12", 12, 128'he98ba06f448c773c8ecc720401002202);
        push("k192_rk13", 13, 128'h0);
        launch(0, 2'b01, K192);
        wait_done(0, n);
        finish_run(0, n);

        push("lat256", -1, 128'd65);
        push("k256_rk0", 0, 128'h603deb1015ca71be2b73aef0857d7781);
        push("k256_rk2", 2, 128'h9ba354118e6925afa51a8b5f2067fcde);
        push("k256_rk3", 3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        push("k256_rk14", 14, 128'hfe4890d1e6188d0b046df344706c631e);
        push("k256_rk15", 15, 128'h0);
        launch(0, 2'b10, K256);
        wait_done(0, n);
        finish_run(0, n);

        rk_idx = 0;
        launch(0, 2'b10, K256);
        repeat (4) @(posedge clk);
        @(negedge clk);
        key_len = 2'b00;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        check("restart_busy", busy, 1'b1);
        check("restart_err", err, 1'b0);
        repeat (15) @(posedge clk);
        #1 rst = 1;
        #1 check("abort_busy", busy, 1'b0);
        check("abort_valid", rk_valid, 1'b0);
        check("abort_rk", rk_out, 128'h0);
        @(negedge clk);
        rst = 0;
        no_done("abort_no_done", 80);
        check("abort_idle", busy, 1'b0);

        push("lat128b", -1, 128'd50);
        push("k128b_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        launch(0, 2'b00, K128);
        wait_done(0, n);
        finish_run(0, n);

        push("lat192_nk6", -1, 128'd54);
        push("nk6_rk12", 12, 128'he98ba06f448c773c8ecc720401002202);
        launch(1, 2'b01, K192);
        wait_done(1, n);
        finish_run(1, n);
        rk_idx = 12;
        launch(1, 2'b10, K256);
        @(negedge clk);
        check("nk6_err", err6, 1'b1);
        check("nk6_busy", busy6, 1'b0);
        check("nk6_valid", rk_valid6, 1'b1);
        check("nk6_rk", rk_out6, 128'he98ba06f448c773c8ecc720401002202);
        @(negedge clk);
        check("nk6_err_clear", err6, 1'b0);

`ifndef AES_KEY_SCHED_ZEROIZE_EN
        push("lat192_dbg", -1, 128'd54);
        push("dbg_rk12", 12, 128'he98ba06f448c773c8ecc720401002202);
`endif
        launch(0, 2'b01, K192);
        repeat (29) @(posedge clk);
        @(negedge clk);
        debug_mode = 1;
        @(posedge clk);
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        @(negedge clk);
        check("zero_busy", busy, 1'b0);
        check("zero_valid", rk_valid, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            rk_idx = 4'(k);
            #1 check("zero_rk", rk_out, 128'h0);
        end
        no_done("zero_no_done", 40);
        debug_mode = 0;
`else
        wait_done(0, n);
        finish_run(0, n + 30);
        debug_mode = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
